// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter: video has fixed top priority, CPU and DMA
// share round-robin; each access lasts ACCESS_CYCLES SRAM cycles.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [20:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        vid_ack,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic [20:0] sram_addr,
  output logic        sram_we_n,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [1:0] G_NONE   = 2'd0;
  localparam logic [1:0] G_VID    = 2'd1;
  localparam logic [1:0] G_CPU    = 2'd2;
  localparam logic [1:0] G_DMA    = 2'd3;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_grant;
  logic [20:0] r_addr;
  logic        r_we;
  logic [7:0]  r_din;
  logic        r_dma_last;
  logic [7:0]  r_rdata;

  logic [1:0]  w_win;
  logic [20:0] w_sel_addr;
  logic        w_sel_we;
  logic [7:0]  w_sel_din;
  logic        w_last;
  logic        w_take;

  // CPU/DMA tie goes to whichever was not served last
  always_comb begin
    w_win = G_NONE;
    if (vid_req)
      w_win = G_VID;
    else if (cpu_req && dma_req)
      w_win = r_dma_last ? G_CPU : G_DMA;
    else if (cpu_req)
      w_win = G_CPU;
    else if (dma_req)
      w_win = G_DMA;
  end

  always_comb begin
    w_sel_addr = vid_addr;
    w_sel_we   = 1'b0;
    w_sel_din  = 8'h00;
    case (w_win)
      G_CPU: begin
        w_sel_addr = cpu_addr;
        w_sel_we   = cpu_we;
        w_sel_din  = cpu_din;
      end
      G_DMA: begin
        w_sel_addr = dma_addr;
        w_sel_we   = dma_we;
        w_sel_din  = dma_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_last    = (r_cnt == 4'd0);
    w_take    = 1'b0;
    sram_we_n = 1'b1;
    sram_doe  = 1'b0;
    vid_ack   = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win != G_NONE) begin
          w_take = 1'b1;
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        sram_doe  = r_we;
        // strobe released in the final cycle to give data hold
        sram_we_n = !(r_we && !w_last);
        if (w_last)
          w_next = S_ACK;
      end
      S_ACK: begin
        vid_ack = (r_grant == G_VID);
        cpu_ack = (r_grant == G_CPU);
        dma_ack = (r_grant == G_DMA);
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_grant    <= G_NONE;
      r_addr     <= 21'd0;
      r_we       <= 1'b0;
      r_din      <= 8'h00;
      r_dma_last <= 1'b1;
      r_rdata    <= 8'h00;
    end else begin
      if (w_take) begin
        r_grant <= w_win;
        r_addr  <= w_sel_addr;
        r_we    <= w_sel_we;
        r_din   <= w_sel_din;
        r_cnt   <= CNT_LOAD;
        if (w_win == G_CPU)
          r_dma_last <= 1'b0;
        else if (w_win == G_DMA)
          r_dma_last <= 1'b1;
      end
      if (r_state == S_ACCESS && !w_last)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_ACCESS && w_last && !r_we)
        r_rdata <= sram_din;
      if (r_state == S_ACK)
        r_grant <= G_NONE;
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_din;
  assign rdata     = r_rdata;
  assign grant     = r_grant;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences,
// and random traffic against a transaction-level model.
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        cpu_req, cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        dma_req, dma_we;
  logic [20:0] dma_addr;
  logic [7:0]  dma_din;
  logic        vid_ack, cpu_ack, dma_ack;
  logic [7:0]  rdata;
  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic [1:0]  grant;

  logic        c4_req, c4_we;
  logic [20:0] c4_addr;
  logic [7:0]  c4_din;
  logic        d4_vack, d4_cack, d4_dack, d4_we_n, d4_doe;
  logic [7:0]  d4_rdata, d4_dout;
  logic [20:0] d4_addr;
  logic [1:0]  d4_grant;
  logic        z1 = 1'b0;
  logic [20:0] z21 = '0;
  logic [7:0]  z8 = '0;

  always #5 sysclk = ~sysclk;

  sram_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
    .sysclk(sysclk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_din(dma_din),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .rdata(rdata), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .grant(grant)
  );

  sram_arbiter #(.ACCESS_CYCLES(4)) u_dut4 (
    .sysclk(sysclk), .reset(reset),
    .vid_req(z1), .vid_addr(z21),
    .cpu_req(c4_req), .cpu_we(c4_we),
    .cpu_addr(c4_addr), .cpu_din(c4_din),
    .dma_req(z1), .dma_we(z1),
    .dma_addr(z21), .dma_din(z8),
    .vid_ack(d4_vack), .cpu_ack(d4_cack), .dma_ack(d4_dack),
    .rdata(d4_rdata), .sram_addr(d4_addr), .sram_we_n(d4_we_n),
    .sram_dout(d4_dout), .sram_doe(d4_doe),
    .sram_din(z8), .grant(d4_grant)
  );

  logic [7:0] mem [0:2097151];
  assign sram_din = mem[sram_addr];
  always @(posedge sysclk)
    if (!sram_we_n) mem[sram_addr] <= sram_dout;

  wire [2:0] acks = {vid_ack, cpu_ack, dma_ack};

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  typedef struct {
    logic       v, c, d;
    logic [1:0] g;
    logic [2:0] ack;
  } vec_t;

  function automatic vec_t mk(input logic v, c, d,
                              input logic [1:0] g,
                              input logic [2:0] ack);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.g = g; r.ack = ack;
    return r;
  endfunction

  vec_t tbl [14];

  // transaction-level model state for the random phase
  logic [7:0]  m_mem [logic [20:0]];
  int          p;
  logic [1:0]  own;
  logic        m_dma_last;
  logic        t_we;
  logic [20:0] t_addr;
  logic [7:0]  t_din;
  logic [20:0] m_addr;
  logic [7:0]  m_rd;

  function automatic logic [7:0] mrd(input logic [20:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return pat(a);
  endfunction

  initial begin
    int nacks;
    int lat;
    logic got;
    logic exp_cpu;
    logic [1:0] e_g;
    logic [2:0] e_ack;
    logic e_doe, e_wen;

    reset = 1'b1;
    vid_req = 0; vid_addr = 21'h0AAAA;
    cpu_req = 0; cpu_we = 0; cpu_addr = 21'h00111; cpu_din = 0;
    dma_req = 0; dma_we = 0; dma_addr = 21'h00222; dma_din = 0;
    c4_req = 0; c4_we = 0; c4_addr = 0; c4_din = 0;
    for (int i = 0; i < 2097152; i++) mem[i] = pat(21'(i));

    tbl[0]  = mk(1, 1, 1, 2'd0, 3'b000);
    tbl[1]  = mk(1, 1, 1, 2'd1, 3'b000);
    tbl[2]  = mk(1, 1, 1, 2'd1, 3'b000);
    tbl[3]  = mk(0, 1, 1, 2'd1, 3'b100);
    tbl[4]  = mk(0, 1, 1, 2'd0, 3'b000);
    tbl[5]  = mk(0, 1, 1, 2'd2, 3'b000);
    tbl[6]  = mk(0, 1, 1, 2'd2, 3'b000);
    tbl[7]  = mk(0, 0, 1, 2'd2, 3'b010);
    tbl[8]  = mk(0, 0, 1, 2'd0, 3'b000);
    tbl[9]  = mk(0, 0, 1, 2'd3, 3'b000);
    tbl[10] = mk(0, 0, 1, 2'd3, 3'b000);
    tbl[11] = mk(0, 0, 0, 2'd3, 3'b001);
    tbl[12] = mk(0, 0, 0, 2'd0, 3'b000);
    tbl[13] = mk(0, 0, 0, 2'd0, 3'b000);

    repeat (2) @(negedge sysclk);
    chk("rst_grant", grant, 0);
    chk("rst_acks", acks, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_doe", sram_doe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // three-way contention
    for (int i = 0; i < 14; i++) begin
      @(negedge sysclk);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_acks", i), acks, tbl[i].ack);
      chk($sformatf("tbl%0d_we_n", i), sram_we_n, 1);
      chk($sformatf("tbl%0d_doe", i), sram_doe, 0);
      vid_req = tbl[i].v;
      cpu_req = tbl[i].c;
      dma_req = tbl[i].d;
    end

    // single CPU read
    mem[21'h00123] = 8'h5A;
    @(negedge sysclk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 21'h00123;
    @(negedge sysclk);
    chk("rd_g1", grant, 2);
    chk("rd_addr", sram_addr, 21'h00123);
    chk("rd_we_n", sram_we_n, 1);
    chk("rd_doe", sram_doe, 0);
    cpu_addr = 21'h1FFFF;
    @(negedge sysclk);
    chk("rd_g2", grant, 2);
    chk("rd_noack", acks, 0);
    @(negedge sysclk);
    chk("rd_ack", acks, 3'b010);
    chk("rd_data", rdata, 8'h5A);
    cpu_req = 0;
    @(negedge sysclk);
    chk("rd_idle_g", grant, 0);
    chk("rd_hold", rdata, 8'h5A);
    chk("rd_addr_hold", sram_addr, 21'h00123);

    // DMA write at top address
    dma_req = 1; dma_we = 1; dma_addr = 21'h1FFFFF; dma_din = 8'hC3;
    @(negedge sysclk);
    chk("wr_g", grant, 3);
    chk("wr_doe1", sram_doe, 1);
    chk("wr_we_n1", sram_we_n, 0);
    chk("wr_dout1", sram_dout, 8'hC3);
    dma_din = 8'h00; dma_addr = 21'h0;
    @(negedge sysclk);
    chk("wr_doe2", sram_doe, 1);
    chk("wr_we_n2", sram_we_n, 1);
    chk("wr_dout2", sram_dout, 8'hC3);
    chk("wr_addr2", sram_addr, 21'h1FFFFF);
    @(negedge sysclk);
    chk("wr_ack", acks, 3'b001);
    chk("wr_doe3", sram_doe, 0);
    dma_req = 0; dma_we = 0;
    @(negedge sysclk);
    chk("wr_mem", mem[21'h1FFFFF], 8'hC3);

    // CPU/DMA held continuously must alternate
    cpu_req = 1; dma_req = 1;
    nacks = 0;
    exp_cpu = 1'b1;
    for (int k = 0; k < 40 && nacks < 6; k++) begin
      @(negedge sysclk);
      if (acks != 0) begin
        chk($sformatf("rr_%0d", nacks), acks,
            exp_cpu ? 3'b010 : 3'b001);
        exp_cpu = !exp_cpu;
        nacks++;
      end
    end
    chk("rr_count", nacks, 6);
    cpu_req = 0; dma_req = 0;

    // reset in the middle of a DMA write
    @(negedge sysclk);
    dma_req = 1; dma_we = 1; dma_addr = 21'h00333; dma_din = 8'h77;
    @(negedge sysclk);
    chk("ab_we_n0", sram_we_n, 0);
    dma_req = 0; dma_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 21'h00444;
    #2 reset = 1'b1;
    #1;
    chk("ab_we_n", sram_we_n, 1);
    chk("ab_grant", grant, 0);
    chk("ab_doe", sram_doe, 0);
    chk("ab_acks", acks, 0);
    chk("ab_rdata", rdata, 0);
    repeat (2) begin
      @(negedge sysclk);
      chk("ab_rst_acks", acks, 0);
    end
    reset = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge sysclk);
      chk("ab_no_dma", dma_ack, 0);
      if (cpu_ack) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("ab_cpu_lat", lat, 3);
    chk("ab_cpu_data", rdata, pat(21'h00444));
    cpu_req = 0;

    // random traffic against the model
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    p = 0; own = 0; m_dma_last = 1'b1; t_we = 0;
    t_addr = 0; t_din = 0; m_addr = 0; m_rd = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge sysclk);
      e_g   = (p == 0) ? 2'd0 : own;
      e_ack = 3'b000;
      if (p == AC + 1)
        e_ack = (own == 1) ? 3'b100 : (own == 2) ? 3'b010 : 3'b001;
      e_doe = t_we && p >= 1 && p <= AC;
      e_wen = !(t_we && p >= 1 && p < AC);
      chk("rnd_grant", grant, e_g);
      chk("rnd_acks", acks, e_ack);
      chk("rnd_doe", sram_doe, e_doe);
      chk("rnd_we_n", sram_we_n, e_wen);
      chk("rnd_addr", sram_addr, m_addr);
      chk("rnd_rdata", rdata, m_rd);
      if (e_doe) chk("rnd_dout", sram_dout, t_din);

      if (vid_req) begin
        if (e_ack[2]) vid_req = ($urandom_range(0, 3) == 0);
      end else vid_req = ($urandom_range(0, 5) == 0);
      if (cpu_req) begin
        if (e_ack[1]) cpu_req = ($urandom_range(0, 3) == 0);
      end else cpu_req = ($urandom_range(0, 2) == 0);
      if (dma_req) begin
        if (e_ack[0]) dma_req = ($urandom_range(0, 3) == 0);
      end else dma_req = ($urandom_range(0, 2) == 0);
      vid_addr = 21'(32'h1000 + $urandom_range(0, 15));
      cpu_addr = 21'(32'h1000 + $urandom_range(0, 15));
      dma_addr = 21'(32'h1000 + $urandom_range(0, 15));
      cpu_din = 8'($urandom);
      dma_din = 8'($urandom);
      cpu_we = ($urandom_range(0, 1) == 1);
      dma_we = ($urandom_range(0, 1) == 1);

      if (p == 0) begin
        if (vid_req || cpu_req || dma_req) begin
          if (vid_req) own = 2'd1;
          else if (cpu_req && (!dma_req || m_dma_last)) own = 2'd2;
          else own = 2'd3;
          if (own == 2'd2) m_dma_last = 1'b0;
          if (own == 2'd3) m_dma_last = 1'b1;
          case (own)
            2'd1: begin t_addr = vid_addr; t_we = 0; t_din = 0; end
            2'd2: begin t_addr = cpu_addr; t_we = cpu_we; t_din = cpu_din; end
            default: begin t_addr = dma_addr; t_we = dma_we; t_din = dma_din; end
          endcase
          m_addr = t_addr;
          p = 1;
        end
      end else if (p <= AC) begin
        if (p == AC) begin
          if (t_we) m_mem[t_addr] = t_din;
          else m_rd = mrd(t_addr);
        end
        p++;
      end else begin
        p = 0;
      end
    end
    vid_req = 0; cpu_req = 0; dma_req = 0;

    // four-cycle write on the second instance
    @(negedge sysclk);
    c4_req = 1; c4_we = 1; c4_addr = 21'h00055; c4_din = 8'hAB;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sysclk);
      chk($sformatf("ac4_g%0d", k), d4_grant, 2);
      chk($sformatf("ac4_ack%0d", k), d4_cack, (k == 5) ? 1 : 0);
      chk($sformatf("ac4_doe%0d", k), d4_doe, (k <= 4) ? 1 : 0);
      chk($sformatf("ac4_we_n%0d", k), d4_we_n, (k <= 3) ? 0 : 1);
      if (k <= 4) chk($sformatf("ac4_dout%0d", k), d4_dout, 8'hAB);
    end
    c4_req = 0; c4_we = 0;
    @(negedge sysclk);
    chk("ac4_idle", d4_grant, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SRAM cycles per access; legal values 2..15.
REQ-002 sysclk  in  1  sole clock; every register updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 vid_req  in  1  video fetch request, read-only, held until vid_ack.
REQ-005 vid_addr  in  21  video address.
REQ-006 cpu_req, cpu_we  in  1 each  CPU request, held until cpu_ack; write when cpu_we=1.
REQ-007 cpu_addr  in  21, cpu_din  in  8  CPU address and write data.
REQ-008 dma_req, dma_we  in  1 each, dma_addr  in  21, dma_din  in  8  DMA port; same meaning as the CPU port.
REQ-009 vid_ack, cpu_ack, dma_ack  out  1 each  one-cycle completion pulse per port.
REQ-010 rdata  out  8  read data; valid in the ack cycle and held until the next read completes.
REQ-011 sram_addr  out  21, sram_we_n  out  1  SRAM address and write strobe.
REQ-012 sram_dout  out  8, sram_doe  out  1, sram_din  in  8  split SRAM data bus; the top level builds the tristate.
REQ-013 grant  out  2  current owner: 0 none, 1 video, 2 cpu, 3 dma.

Function
REQ-014 Three-state FSM (IDLE, ACCESS, ACK) shall be the only sequencer.
REQ-015 IDLE with no req: grant=0, sram_we_n=1, sram_doe=0, sram_addr holds its last value.
REQ-016 IDLE with any req: pick winner, latch its addr/we/din, load counter=ACCESS_CYCLES-1, go to ACCESS next edge.
REQ-017 Priority: vid_req strictly highest; CPU vs DMA round-robin.
REQ-018 Round-robin: last-served-of-CPU/DMA flag; on tie the port not served last wins; video grants leave the flag unchanged.
REQ-019 ACCESS: sram_addr = latched address for all ACCESS_CYCLES cycles; counter decrements each cycle; leave for ACK when counter=0.
REQ-020 Write: sram_doe=1 and sram_dout = latched data for every ACCESS cycle; sram_we_n=0 for every ACCESS cycle except the last, where it is 1 (data hold).
REQ-021 Read: sram_doe=0 and sram_we_n=1 throughout; rdata captures sram_din at the end of the last ACCESS cycle.
REQ-022 ACK: the granted port's ack=1 for exactly one cycle, grant still shows the owner, sram_we_n=1, sram_doe=0; next state IDLE.
REQ-023 Latency: req seen in IDLE at cycle t gives ACCESS cycles t+1..t+ACCESS_CYCLES, ack at t+ACCESS_CYCLES+1, IDLE again at t+ACCESS_CYCLES+2.
REQ-024 Requesters drop req in the cycle after their ack; req still high in IDLE is a new request.
REQ-025 Requests in ACCESS/ACK are not sampled; they wait, and a late video request beats a waiting CPU/DMA request at the next IDLE.
REQ-026 Input changes to the owner's addr/we/din after the IDLE latch do not affect the transaction.
REQ-027 At most one ack is high in any cycle; an ack only ever goes to the port latched in IDLE.

Reset
REQ-028 While reset=1, regardless of clock: state IDLE, grant=0, all acks 0, sram_we_n=1, sram_doe=0, sram_addr=0, sram_dout=0, rdata=0, counter=0, round-robin flag = DMA last (CPU wins the first tie).
REQ-029 Reset mid-ACCESS aborts the transaction with no ack; sram_we_n goes to 1 asynchronously.
REQ-030 First request after reset release is arbitrated in IDLE as in REQ-016.

Verification
REQ-031 Single CPU read, ACCESS_CYCLES=2, cpu_addr=0x00123, SRAM model returns 0x5A -> grant=2 two cycles, cpu_ack at t+3, rdata=0x5A.
REQ-032 DMA write 0xC3 to 0x1FFFFF -> sram_doe=1 both ACCESS cycles, sram_we_n low only in the first, dma_ack at t+3, SRAM model holds 0xC3.
REQ-033 vid_req, cpu_req, dma_req all high at once, each held until its ack -> order video, CPU, DMA; acks at t+3, t+7, t+11; never two acks together.
REQ-034 CPU and DMA held continuously, each re-requesting after its ack -> grants strictly alternate CPU, DMA, CPU, DMA.
REQ-035 Reset asserted in the middle of a DMA write -> sram_we_n=1 and grant=0 immediately, dma_ack never pulses; after release a pending cpu_req is served normally.
REQ-036 ACCESS_CYCLES=4 CPU write -> four ACCESS cycles, sram_we_n low for three, ack at t+5.
